aes_dec_iter: RTL and testbench

AES_DEC_ITER -- requirements
Module: aes_dec_iter

---
 rtl/aes_dec_iter.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_aes_dec_iter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryptor: one round per clock, valid/ready on both sides.
// Define AES_DEC_DISPLAY_EN to add the registered 3-digit sev_seg readout.
package aes_dec_pkg;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    // a^254 is the field inverse, and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return 8'((a << n) | (a >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r)&3)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = isbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                             ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                             ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                             ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                             ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Round r occupies fk[128*r+127 -: 128]; round 0 is the cipher key
    function automatic logic [1407:0] key_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        logic [1407:0] fk;
        fk = '0;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])}
                  ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            fk[128*r+127 -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return fk;
    endfunction

endpackage

module key_expansion #(
    parameter int NR = 10,
    parameter int NW = 4
) (
    input  logic [32*NW-1:0]      key,
    output logic [128*(NR+1)-1:0] full_key
);
    import aes_dec_pkg::*;

    assign full_key = key_expand(key);

endmodule

`ifdef AES_DEC_DISPLAY_EN
module binary_to_bcd (
    input  logic [7:0]  bin,
    output logic [11:0] bcd
);
    always_comb begin
        bcd = '0;
        for (int i = 7; i >= 0; i--) begin
            if (bcd[3:0] > 4'd4)  bcd[3:0]  = bcd[3:0]  + 4'd3;
            if (bcd[7:4] > 4'd4)  bcd[7:4]  = bcd[7:4]  + 4'd3;
            if (bcd[11:8] > 4'd4) bcd[11:8] = bcd[11:8] + 4'd3;
            bcd = {bcd[10:0], bin[i]};
        end
    end
endmodule

module seven_seg (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    // segment order gfedcba, active high
    always_comb begin
        seg = 7'h00;
        case (digit)
            4'd0: seg = 7'h3f;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5b;
            4'd3: seg = 7'h4f;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6d;
            4'd6: seg = 7'h7d;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7f;
            4'd9: seg = 7'h6f;
            default: seg = 7'h00;
        endcase
    end
endmodule
`endif

module aes_dec_iter #(
    parameter int NR = 10,
    parameter int NW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
`ifdef AES_DEC_DISPLAY_EN
    output logic [20:0]  sev_seg,
`endif
    output logic         busy
);
    import aes_dec_pkg::*;

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

    state_t                 state, state_nx;
    logic [127:0]           ct_reg;
    logic [32*NW-1:0]       key_reg;
    logic [127:0]           st;
    logic [3:0]             rnd;
    logic [128*(NR+1)-1:0]  full_key;
    logic [3:0]             rk_sel;
    logic [127:0]           rk;
    logic [127:0]           sub_out;

    key_expansion #(.NR(NR), .NW(NW)) u_key_exp (
        .key      (key_reg),
        .full_key (full_key)
    );

    // LOAD whitens with the last round key; later states walk rnd down to 0
    assign rk_sel  = (state == LOAD) ? 4'(NR) : rnd;
    assign rk      = full_key[{rk_sel, 7'd0} +: 128];
    assign sub_out = inv_sub_bytes(inv_shift_rows(st));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = LOAD;
            end
            LOAD:  state_nx = ROUND;
            ROUND: if (rnd == 4'd1) state_nx = FINAL;
            FINAL: state_nx = DONE;
            DONE:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ct_reg    <= '0;
            key_reg   <= '0;
            st        <= '0;
            rnd       <= '0;
            plaintext <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ct_reg  <= ciphertext;
                    key_reg <= key;
                end
                LOAD: begin
                    st  <= ct_reg ^ rk;
                    rnd <= 4'(NR - 1);
                end
                ROUND: begin
                    st  <= inv_mix_columns(sub_out ^ rk);
                    rnd <= rnd - 4'd1;
                end
                FINAL: begin
                    plaintext <= sub_out ^ rk;
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef AES_DEC_DISPLAY_EN
    logic [11:0] bcd;
    logic [6:0]  seg_h, seg_t, seg_u;

    binary_to_bcd u_bcd (.bin(plaintext[7:0]), .bcd(bcd));
    seven_seg u_seg_h (.digit(bcd[11:8]), .seg(seg_h));
    seven_seg u_seg_t (.digit(bcd[7:4]),  .seg(seg_t));
    seven_seg u_seg_u (.digit(bcd[3:0]),  .seg(seg_u));

    always_ff @(posedge clk) begin
        if (rst) sev_seg <= {3{7'h3f}};
        else     sev_seg <= {seg_h, seg_t, seg_u};
    end
`endif

endmodule

// File: tb/tb_aes_dec_iter.sv
// Scoreboard bench for aes_dec_iter: FIPS-197 vectors, hold, busy-offer,
// mid-round reset and back-to-back spacing.
module tb_aes_dec_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] ciphertext = '0;
    logic [127:0] key = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] plaintext;
`ifdef AES_DEC_DISPLAY_EN
    logic [20:0]  sev_seg;
`endif

    always #5 clk = ~clk;

    aes_dec_iter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
`ifdef AES_DEC_DISPLAY_EN
        .sev_seg    (sev_seg),
`endif
        .busy       (busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int last_acc = 0;
    int prev_acc = 0;
    logic [127:0] exp_pt = '0;
    logic [127:0] exp_q [$];
    int acc_q [$];
    logic prev_ov = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Inputs change just after a rising edge, so values seen here are
    // the ones the next edge will sample.
    always @(negedge clk) begin
        logic [127:0] e;
        int a;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(exp_pt);
            acc_q.push_back(cyc + 1);
            prev_acc = last_acc;
            last_acc = cyc + 1;
            acc_cnt++;
        end
        if (out_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("plaintext", plaintext, e);
                check("latency", cyc - a, 11);
            end
        end
        prev_ov = out_valid;
    end

    task automatic drive(input logic [127:0] ct, input logic [127:0] k,
                         input logic [127:0] pt);
        ciphertext = ct;
        key        = k;
        exp_pt     = pt;
        in_valid   = 1'b1;
    endtask

    task automatic offer(input logic [127:0] ct, input logic [127:0] k,
                         input logic [127:0] pt);
        int n;
        n = acc_cnt;
        drive(ct, k, pt);
        for (int i = 0; i < 40 && acc_cnt == n; i++) begin
            @(posedge clk);
            #1;
        end
        check("accept", acc_cnt != n, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("out_timeout", ok, 1'b1);
    endtask

    initial begin
        int n;
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ov", out_valid, 1'b0);
        check("rst_pt", plaintext, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_rdy", in_ready, 1'b1);
`ifdef AES_DEC_DISPLAY_EN
        check("rst_seg", sev_seg, {7'h3f, 7'h3f, 7'h3f});
`endif
        rst = 1'b0;
        out_ready = 1'b1;

        offer(C1_CT, C1_KEY, C1_PT);
        check("busy_run", busy, 1'b1);
        wait_out(20);
        @(posedge clk);
        #1;
        check("idle_t1", in_ready, 1'b1);
`ifdef AES_DEC_DISPLAY_EN
        check("sev_seg_255", sev_seg, {7'h5b, 7'h6d, 7'h6d});
`endif

        out_ready = 1'b0;
        offer(C1_CT, C1_KEY, C1_PT);
        drive(B_CT, B_KEY, B_PT);
        wait_out(20);
        for (int i = 0; i < 20; i++) begin
            check("hold_ov", out_valid, 1'b1);
            check("hold_pt", plaintext, C1_PT);
            check("hold_rdy", in_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_hold", in_ready, 1'b1);
        check("ov_drop", out_valid, 1'b0);
        offer(B_CT, B_KEY, B_PT);
        wait_out(20);
        @(posedge clk);
        #1;

        offer(C1_CT, C1_KEY, C1_PT);
        repeat (5) @(posedge clk);
        #1;
        check("busy_mid", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ov", out_valid, 1'b0);
        check("abort_pt", plaintext, '0);
        check("abort_rdy", in_ready, 1'b1);
        offer(C1_CT, C1_KEY, C1_PT);
        wait_out(20);
        @(posedge clk);
        #1;

        n = acc_cnt;
        drive(C1_CT, C1_KEY, C1_PT);
        for (int i = 0; i < 40 && acc_cnt < n + 2; i++) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("b2b_accepts", acc_cnt - n, 2);
        check("busy_between", last_acc - prev_acc - 1, 12);

        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", ok, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
